wb_cache_ctrl: RTL
==================

# wb_cache_ctrl

Parametrised write-back cache controller FSM that sequences lookup, dirty-line eviction, multi-beat line fill and tag update for a direct-mapped cache. It sits between the CPU-side request port and the memory burst interface. It drives the tag/data array strobes but contains no storage of its own. Compared with the single-beat controller, it adds configurable line length (burst beats), a write-allocate/no-allocate mode, a ready/valid request handshake and saturating hit/miss statistics.

## Interface
Parameters:
- BEATS, 4: words per cache line; power of two, 2..16.
- WRITE_ALLOC, 1: 1 = write-allocate; 0 = write miss is a single-beat write-through with no fill.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_wr  in  1  1 = write, 0 = read; sampled with the handshake.
- req_ready  out  1  high only in IDLE.
- hit  in  1  tag compare result; valid in LOOKUP only.
- dirty  in  1  victim line dirty bit; valid in LOOKUP only.
- mem_req  out  1  burst request; held until mem_ack.
- mem_wr  out  1  1 = write burst, 0 = read burst; stable while mem_req is high.
- mem_single  out  1  burst is one beat (write-through).
- mem_ack  in  1  memory accepted the burst.
- mem_beat  in  1  one beat transferred.
- beat_idx  out  $clog2(BEATS)  current word within the line.
- arr_we  out  1  data-array write (fill beat or CPU write hit).
- tag_we  out  1  tag/valid write.
- set_dirty  out  1  set the dirty bit of the indexed line.
- clr_dirty  out  1  clear the dirty bit of the indexed line.
- resp_valid  out  1  one-cycle completion pulse.
- idle  out  1  high in IDLE.
- hit_cnt  out  CNT_W  saturating lookup-hit count.
- miss_cnt  out  CNT_W  saturating lookup-miss count.

## Operation
States: IDLE, LOOKUP, EVICT, FILL, WTHRU, UPDATE, RESP.

- **IDLE:** req_ready=1, idle=1. A handshake (req_valid && req_ready) latches req_wr and moves to LOOKUP.
- **LOOKUP:**
  - hit: increment hit_cnt. If write: arr_we=1, set_dirty=1. Go to RESP.
  - miss: increment miss_cnt.
    - write && !WRITE_ALLOC: go to WTHRU.
    - dirty: go to EVICT.
    - otherwise: go to FILL.
- **EVICT:** mem_req=1, mem_wr=1 until mem_ack. Then each mem_beat advances beat_idx. The beat with beat_idx==BEATS-1 goes to FILL, and beat_idx wraps to 0.
- **FILL:** mem_req=1, mem_wr=0 until mem_ack. Each mem_beat asserts arr_we combinationally with the current beat_idx. The last beat goes to UPDATE.
- **WTHRU:** mem_req=1, mem_wr=1, mem_single=1 until mem_ack. The first mem_beat goes to RESP. Cache contents are untouched.
- **UPDATE:** tag_we=1 for one cycle.
  - Read: clr_dirty=1.
  - Write-allocate: arr_we=1 and set_dirty=1 (CPU word merged); clr_dirty=0.
  - Go to RESP.
- **RESP:** resp_valid=1 for one cycle, then IDLE.

Rules:
- mem_beat is ignored before mem_ack in the same burst, and ignored in all non-memory states.
- mem_ack and mem_beat asserted in the same cycle: the ack is taken and that beat counts.
- Counters saturate at 2^CNT_W-1; they never wrap.
- hit/dirty are ignored outside LOOKUP.

## Timing
- Reset: the state is IDLE and beat_idx, hit_cnt and miss_cnt are 0. req_ready=1 and idle=1; every other output is 0. Reset mid-burst abandons the transfer immediately, with no resp_valid.
- Read hit: handshake in cycle 0, LOOKUP in cycle 1, resp_valid in cycle 2.
- Clean read miss, with mem_ack in the first FILL cycle and back-to-back beats:
  - FILL runs from cycle 2 to cycle 2+BEATS-1.
  - UPDATE is at cycle 2+BEATS.
  - resp_valid is at cycle 3+BEATS.
- Dirty miss adds BEATS cycles plus the ack wait.
- All outputs are Moore decodes of state, except arr_we in FILL (gated by mem_beat) and the LOOKUP strobes (gated by hit/req_wr).

## Structure
- Package cache_ctrl_pkg holds:
  - the state enum;
  - the mode localparams WA_ALLOC and WA_NOALLOC;
  - the function BEAT_W(BEATS) = $clog2(BEATS).
- Sub-module beat_counter (ports: clk, rst, clr, inc; outputs idx, last) is shared by EVICT and FILL.

## Test plan
- Read hit, BEATS=4: req_valid with req_wr=0, hit=1 → resp_valid at cycle 2; hit_cnt=1; no mem_req.
- Clean read miss, BEATS=4, mem_ack immediate, 4 consecutive beats:
  - arr_we high with beat_idx 0,1,2,3;
  - tag_we and clr_dirty at cycle 6;
  - resp_valid at cycle 7.
- Dirty write miss, WRITE_ALLOC=1, BEATS=8, mem_ack delayed 3 cycles:
  - 8 write beats, then 8 read beats;
  - UPDATE asserts set_dirty and arr_we;
  - miss_cnt=1.
- Write miss, WRITE_ALLOC=0: mem_single=1, mem_wr=1, one beat → resp_valid; no tag_we, no arr_we.
- rst asserted at FILL beat 2 → next cycle IDLE, beat_idx=0, counters 0, no resp_valid. A following request completes normally.
- CNT_W=2, 5 hits → hit_cnt stays at 3.

Source files
------------

// File: rtl/wb_cache_ctrl_pkg.sv
// Shared types and helpers for the write-back cache controller.
package cache_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_EVICT,
        ST_FILL,
        ST_WTHRU,
        ST_UPDATE,
        ST_RESP
    } state_t;

    localparam logic WA_NOALLOC = 1'b0;
    localparam logic WA_ALLOC   = 1'b1;

    function automatic int BEAT_W(input int beats);
        return $clog2(beats);
    endfunction

endpackage

// File: rtl/wb_cache_ctrl_beat_counter.sv
// Word-within-line counter shared by the eviction and fill bursts.
// Wraps to 0 after the last beat so a fill that follows an eviction
// starts from word 0 without an explicit clear.
module beat_counter
    import cache_ctrl_pkg::*;
#(
    parameter int BEATS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      inc,
    output logic [BEAT_W(BEATS)-1:0]  idx,
    output logic                      last
);

    localparam int BW = BEAT_W(BEATS);
    localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);

    assign last = (idx == LAST_IDX);

    // Advance on each counted beat, wrapping after the final word.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/wb_cache_ctrl.sv
// Write-back, direct-mapped cache controller FSM.
//
// state  | meaning
// IDLE   | ready for a CPU request
// LOOKUP | tag compare result valid; hit completes, miss picks a path
// EVICT  | write dirty victim line back, BEATS beats
// FILL   | read the new line, one array write per beat
// WTHRU  | single-beat write-through (no-allocate write miss)
// UPDATE | write tag, merge CPU word on write-allocate
// RESP   | one-cycle completion pulse
module wb_cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int BEATS       = 4,
    parameter bit WRITE_ALLOC = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic                      req_wr,
    output logic                      req_ready,
    input  logic                      hit,
    input  logic                      dirty,
    output logic                      mem_req,
    output logic                      mem_wr,
    output logic                      mem_single,
    input  logic                      mem_ack,
    input  logic                      mem_beat,
    output logic [BEAT_W(BEATS)-1:0]  beat_idx,
    output logic                      arr_we,
    output logic                      tag_we,
    output logic                      set_dirty,
    output logic                      clr_dirty,
    output logic                      resp_valid,
    output logic                      idle,
    output logic [CNT_W-1:0]          hit_cnt,
    output logic [CNT_W-1:0]          miss_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state_q, state_d;
    logic   wr_q;
    logic   acked_q, acked_d;
    logic   inc_hit, inc_miss;
    logic   beat_inc, beat_clr, beat_last;
    logic   beat_ok;

    // A beat only counts once the burst has been accepted; an ack and a
    // beat in the same cycle count together.
    assign beat_ok  = (acked_q || mem_ack) && mem_beat;
    assign beat_clr = (state_q == ST_IDLE);

    beat_counter #(.BEATS(BEATS)) u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (beat_clr),
        .inc  (beat_inc),
        .idx  (beat_idx),
        .last (beat_last)
    );

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        idle       = 1'b0;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_single = 1'b0;
        arr_we     = 1'b0;
        tag_we     = 1'b0;
        set_dirty  = 1'b0;
        clr_dirty  = 1'b0;
        resp_valid = 1'b0;
        inc_hit    = 1'b0;
        inc_miss   = 1'b0;
        beat_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                idle      = 1'b1;
                if (req_valid) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (hit) begin
                    inc_hit   = 1'b1;
                    arr_we    = wr_q;
                    set_dirty = wr_q;
                    state_d   = ST_RESP;
                end else begin
                    inc_miss = 1'b1;
                    if (wr_q && (WRITE_ALLOC == WA_NOALLOC)) state_d = ST_WTHRU;
                    else if (dirty)                          state_d = ST_EVICT;
                    else                                     state_d = ST_FILL;
                end
            end
            ST_EVICT: begin
                mem_req = !acked_q;
                mem_wr  = 1'b1;
                if (beat_ok) begin
                    beat_inc = 1'b1;
                    if (beat_last) state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                mem_req = !acked_q;
                if (beat_ok) begin
                    arr_we   = 1'b1;
                    beat_inc = 1'b1;
                    if (beat_last) state_d = ST_UPDATE;
                end
            end
            ST_WTHRU: begin
                mem_req    = !acked_q;
                mem_wr     = 1'b1;
                mem_single = 1'b1;
                if (beat_ok) state_d = ST_RESP;
            end
            ST_UPDATE: begin
                tag_we    = 1'b1;
                arr_we    = wr_q;
                set_dirty = wr_q;
                clr_dirty = !wr_q;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ack is remembered for the rest of the current burst only.
    always_comb begin
        acked_d = acked_q;
        if (state_d != state_q)     acked_d = 1'b0;
        else if (mem_req && mem_ack) acked_d = 1'b1;
    end

    // State, latched request direction, ack flag and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_q     <= 1'b0;
            acked_q  <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state_q <= state_d;
            acked_q <= acked_d;
            if (state_q == ST_IDLE && req_valid) wr_q <= req_wr;
            if (inc_hit && hit_cnt != CNT_MAX)   hit_cnt  <= hit_cnt + 1'b1;
            if (inc_miss && miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + 1'b1;
        end
    end

endmodule
